// File: rtl/stream_minmax_reduce.sv
// Streaming min/max reduction over valid/ready frames: reports the extremum, its index and the frame length.
// Optional macro STREAM_MINMAX_BOTH_EN adds the opposite extremum on out_alt_data/out_alt_index.
module stream_minmax_reduce #(
  parameter int WIDTH  = 32,
  parameter int LEN_W  = 8,
  parameter int SIGNED = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_max,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [LEN_W-1:0] out_index,
  output logic [LEN_W-1:0] out_count,
  output logic             out_ovf
`ifdef STREAM_MINMAX_BOTH_EN
  ,
  output logic [WIDTH-1:0] out_alt_data,
  output logic [LEN_W-1:0] out_alt_index
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_HOLD} state_t;

  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  function automatic logic less_than(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) < $signed(b);
    else             return a < b;
  endfunction

  function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] c);
    return (c == CNT_MAX) ? c : c + LEN_W'(1);
  endfunction

  state_t           r_state;
  logic             r_mode;
  logic [WIDTH-1:0] r_acc;
  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] r_cnt;
  logic             r_ovf;

  logic             w_beat;
  logic             w_first;
  logic             w_mode;
  logic             w_repl;
  logic [WIDTH-1:0] w_nxt_acc;
  logic [LEN_W-1:0] w_nxt_idx;
  logic [LEN_W-1:0] w_nxt_cnt;
  logic             w_nxt_ovf;

  assign in_ready  = (r_state != S_HOLD);
  assign w_beat    = in_valid & in_ready;
  assign w_first   = (r_state == S_IDLE);
  // Mode is frozen on the first beat so mid-frame toggles are ignored
  assign w_mode    = w_first ? mode_max : r_mode;
  assign w_repl    = w_mode ? less_than(r_acc, in_data) : less_than(in_data, r_acc);
  assign w_nxt_acc = (w_first || w_repl) ? in_data : r_acc;
  assign w_nxt_idx = w_first ? '0 : (w_repl ? r_cnt : r_idx);
  assign w_nxt_cnt = w_first ? LEN_W'(1) : sat_inc(r_cnt);
  assign w_nxt_ovf = w_first ? 1'b0 : (r_ovf | (r_cnt == CNT_MAX));

`ifdef STREAM_MINMAX_BOTH_EN
  logic [WIDTH-1:0] r_alt_acc;
  logic [LEN_W-1:0] r_alt_idx;
  logic             w_alt_repl;
  logic [WIDTH-1:0] w_nxt_alt_acc;
  logic [LEN_W-1:0] w_nxt_alt_idx;

  assign w_alt_repl    = w_mode ? less_than(in_data, r_alt_acc) : less_than(r_alt_acc, in_data);
  assign w_nxt_alt_acc = (w_first || w_alt_repl) ? in_data : r_alt_acc;
  assign w_nxt_alt_idx = w_first ? '0 : (w_alt_repl ? r_cnt : r_alt_idx);

  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_alt_acc <= w_nxt_alt_acc;
      r_alt_idx <= w_nxt_alt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_alt_data  <= '0;
      out_alt_index <= '0;
    end else if (w_beat && in_last) begin
      out_alt_data  <= w_nxt_alt_acc;
      out_alt_index <= w_nxt_alt_idx;
    end
  end
`endif

  // Accumulator stage: working values, overwritten by the first beat of every frame
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_mode <= w_mode;
      r_acc  <= w_nxt_acc;
      r_idx  <= w_nxt_idx;
      r_cnt  <= w_nxt_cnt;
      r_ovf  <= w_nxt_ovf;
    end
  end

  // Result stage: outputs load on the last beat and hold until the next result
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_ACC: begin
          if (w_beat) begin
            if (in_last) begin
              r_state   <= S_HOLD;
              out_valid <= 1'b1;
              out_data  <= w_nxt_acc;
              out_index <= w_nxt_idx;
              out_count <= w_nxt_cnt;
              out_ovf   <= w_nxt_ovf;
            end else begin
              r_state <= S_ACC;
            end
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_state   <= S_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/stream_minmax_reduce.md
Name: stream_minmax_reduce

Overview:
- Streaming successor to the flat 32-bit two-operand unsigned min comparator.
- Reduces a variable-length frame of WIDTH-bit operands to its minimum or maximum, and reports the element's index and the frame length.
- Generalised in width, signedness and mode (min/max).
- Sits between a valid/ready producer and consumer in the FHE-benchmark datapath; one operand accepted per cycle.

Parameters:
- WIDTH, 32, operand width in bits (>=2).
- LEN_W, 8, width of index/count fields; max representable frame length is 2^LEN_W - 1.
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- mode_max  in  1  1 = max, 0 = min; sampled on the first beat of each frame only
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept operand
- in_data  in  WIDTH  operand
- in_last  in  1  final operand of frame
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  extremum value
- out_index  out  LEN_W  zero-based index of the extremum within the frame
- out_count  out  LEN_W  number of operands in the frame (saturating)
- out_ovf  out  1  frame exceeded 2^LEN_W - 1 operands

Behaviour:
- Accept condition: in_valid & in_ready.
- Reset: state=IDLE; out_valid=0, out_data=0, out_index=0, out_count=0, out_ovf=0; in_ready=1 in the cycle after rst deasserts. Reset mid-frame or mid-HOLD discards everything.
- FSM states: IDLE (no operand yet), ACC (accumulating), HOLD (result presented).
- in_ready=1 in IDLE and ACC; in_ready=0 in HOLD.
- IDLE, accepted beat:
  - acc=in_data, idx=0, cnt=1, ovf=0, mode latched.
  - in_last=1 -> HOLD; else -> ACC.
- ACC, accepted beat, with position p = current cnt:
  - min mode: replace acc/idx when in_data < acc (strict).
  - max mode: replace acc/idx when in_data > acc (strict).
  - Ties keep the earlier index.
  - cnt increments, saturating at 2^LEN_W - 1. ovf is set sticky when a beat arrives with cnt already saturated.
  - Once saturated, the recorded index for later replacements is 2^LEN_W - 1.
  - in_last=1 -> HOLD.
- Compare is unsigned, or signed when SIGNED=1, over the full WIDTH. No partial-width truncation.
- Latency: last beat accepted at cycle t -> out_valid=1 at t+1 with final values. A single-beat frame gives out_index=0, out_count=1.
- HOLD:
  - out_* stable while out_valid & !out_ready.
  - On the out_ready handshake -> IDLE, out_valid=0 next cycle, in_ready=1 next cycle.
  - One bubble cycle between frames is required behaviour.
- mode_max changes mid-frame are ignored.
- in_valid=0 cycles in ACC leave state unchanged.
- out_data/out_index/out_count/out_ovf hold their last values after the handshake until the next result.

Optional Feature:
- Macro: STREAM_MINMAX_BOTH_EN.
- Defined:
  - Adds ports out_alt_data (out, WIDTH) and out_alt_index (out, LEN_W), carrying the opposite extremum (max when mode_max=0, min when mode_max=1).
  - Same tie rule (earlier index wins), same timing and hold rules, reset to 0.
- Undefined: ports absent; no second comparator or registers synthesised.

Test Plan:
- Unsigned min, WIDTH=32: frame {7, 3, 9, 3(last)} -> out_data=3, out_index=1, out_count=4, out_ovf=0, out_valid one cycle after the last beat.
- SIGNED=1 max: frame {0xFFFFFFFF, 0x00000002, 0x80000000(last)} -> out_data=2, out_index=1. Same frame with SIGNED=0 -> out_data=0xFFFFFFFF, out_index=0.
- Single-beat frame {0x5A, last}, mode_max=1 -> out_data=0x5A, index 0, count 1. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout.
- LEN_W=2: 5-operand frame {4,3,2,1,0(last)}, min -> out_count=3, out_ovf=1, out_data=0, out_index=3.
- Assert rst mid-frame after 2 beats, then send {10, 20(last)} min -> out_data=10, index 0, count 2, with no residue from the aborted frame.
- STREAM_MINMAX_BOTH_EN: frame {5, 1, 8(last)}, mode_max=0 -> out_data=1/idx1, out_alt_data=8/idx2. Back-to-back frames with out_ready=1 show exactly one in_ready=0 bubble.
